// File: rtl/io_bus_pkg.sv
// Shared widths, FSM state encoding and default error data for the I/O bus master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_bus_pkg;

    localparam int IO_ADDR_W = 16;
    localparam int IO_DATA_W = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        ISSUE    = ST_ISSUE,
        WAIT_ACK = ST_WAIT_ACK,
        RESP     = ST_RESP
    } state_t;

    // Returned as read data when no slave answers in time.
    localparam logic [IO_DATA_W-1:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_bus_master_if.sv
// Command, response and programmable I/O bus signals of the bus master.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready on commands, rsp_valid/rsp_ready on responses.
interface io_bus_master_if #(
    parameter int N_SLAVES = 8
);
    import io_bus_pkg::*;

    // command side
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_wr;
    logic [31:0]                   cmd_addr;
    logic [IO_DATA_W-1:0]          cmd_wdata;

    // response side
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [IO_DATA_W-1:0]          rsp_data;
    logic                          rsp_err;

    // programmable I/O bus
    logic [N_SLAVES-1:0]           io_sel;
    logic                          io_sync;
    logic [IO_ADDR_W-1:0]          io_addr;
    logic                          io_rd_en;
    logic                          io_wr_en;
    logic [IO_DATA_W-1:0]          io_wr_data;
    logic [IO_DATA_W*N_SLAVES-1:0] io_rd_data;
    logic [N_SLAVES-1:0]           io_rd_ack;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  io_rd_data, io_rd_ack,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_err,
        output io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output rsp_ready,
        output io_rd_data, io_rd_ack,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_err,
        input  io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data
    );

endinterface

// File: rtl/io_rd_ack_arb.sv
// Priority encoder over the per-slave read acks plus the matching read-data mux.
// Latency: combinational.
// Backpressure: none; the FSM decides when the result is used.
module io_rd_ack_arb
    import io_bus_pkg::*;
#(
    parameter int N_SLAVES = 8
) (
    input  logic [N_SLAVES-1:0]           io_rd_ack,
    input  logic [IO_DATA_W*N_SLAVES-1:0] io_rd_data,
    output logic                          any_ack,
    output logic                          multi_ack,
    output logic [IO_DATA_W-1:0]          sel_data
);

    localparam logic [N_SLAVES-1:0] ACK_ONE = N_SLAVES'(1);

    // Scan from the top down so the lowest acking slave wins the mux.
    always_comb begin
        sel_data = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (io_rd_ack[k]) begin
                sel_data = io_rd_data[IO_DATA_W*k +: IO_DATA_W];
            end
        end
    end

    assign any_ack   = |io_rd_ack;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_ack = |(io_rd_ack & (io_rd_ack - ACK_ONE));

endmodule

// File: rtl/io_bus_master.sv
// Runs one programmable I/O bus transaction per command and returns data/status.
// Latency: write rsp 2 cycles after accept, read 3+ack delay, timeout TIMEOUT+3, bad slave 1.
// Backpressure: one command in flight; cmd_ready low until the response handshake completes.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int                   N_SLAVES = 8,
    parameter int                   TIMEOUT  = 15,
    parameter logic [IO_DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic            io_clk,
    input  logic            reset_n,
    io_bus_master_if.master bus
);

    localparam logic [15:0]         N_SLAVES_W = 16'(N_SLAVES);
    localparam logic [7:0]          TMO_LOAD   = 8'(TIMEOUT);
    localparam logic [N_SLAVES-1:0] SEL_ONE    = N_SLAVES'(1);

    state_t               state;
    logic [7:0]           tmo_cnt;
    logic                 idx_ok;
    logic [N_SLAVES-1:0]  sel_onehot;
    logic                 any_ack;
    logic                 multi_ack;
    logic [IO_DATA_W-1:0] sel_data;

    assign idx_ok     = bus.cmd_addr[31:16] < N_SLAVES_W;
    assign sel_onehot = SEL_ONE << bus.cmd_addr[31:16];

    io_rd_ack_arb #(
        .N_SLAVES (N_SLAVES)
    ) u_ack_arb (
        .io_rd_ack  (bus.io_rd_ack),
        .io_rd_data (bus.io_rd_data),
        .any_ack    (any_ack),
        .multi_ack  (multi_ack),
        .sel_data   (sel_data)
    );

    // Transaction FSM; every output is a register driven from here.
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_err    <= 1'b0;
            bus.io_sel     <= '0;
            bus.io_sync    <= 1'b0;
            bus.io_addr    <= '0;
            bus.io_rd_en   <= 1'b0;
            bus.io_wr_en   <= 1'b0;
            bus.io_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready comes up one cycle after reset release.
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        if (idx_ok) begin
                            state          <= ISSUE;
                            bus.io_sel     <= sel_onehot;
                            bus.io_addr    <= bus.cmd_addr[IO_ADDR_W-1:0];
                            bus.io_wr_data <= bus.cmd_wdata;
                            bus.io_wr_en   <= bus.cmd_wr;
                            bus.io_rd_en   <= ~bus.cmd_wr;
                            bus.io_sync    <= 1'b1;
                        end else begin
                            // No such slave: answer with an error, never touch the bus.
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= '0;
                            bus.rsp_err   <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    bus.io_sync <= 1'b0;
                    if (bus.io_wr_en) begin
                        // Slave captures the write on this edge; nothing to wait for.
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.io_sel    <= '0;
                        bus.io_wr_en  <= 1'b0;
                    end else begin
                        state   <= WAIT_ACK;
                        tmo_cnt <= TMO_LOAD;
                    end
                end

                WAIT_ACK: begin
                    if (any_ack) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= sel_data;
                        bus.rsp_err   <= multi_ack;
                        bus.io_sel    <= '0;
                        bus.io_rd_en  <= 1'b0;
                    end else if (tmo_cnt == 8'd0) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= ERR_DATA;
                        bus.rsp_err   <= 1'b1;
                        bus.io_sel    <= '0;
                        bus.io_rd_en  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt - 8'd1;
                    end
                end

                RESP: begin
                    // rsp_data/rsp_err are left alone here, so they hold until accepted.
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed and randomized checks of io_bus_master against a transaction-level model.
// Latency: n/a.
// Backpressure: rsp_ready is held low for a random number of cycles per transaction.
module tb_io_bus_master;
    import io_bus_pkg::*;

    localparam int          NS   = 8;
    localparam int          TMO  = 15;
    localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

    logic io_clk  = 1'b0;
    logic reset_n = 1'b0;

    always #5 io_clk = ~io_clk;

    io_bus_master_if #(.N_SLAVES(NS)) bus ();

    io_bus_master #(
        .N_SLAVES (NS),
        .TIMEOUT  (TMO),
        .ERR_DATA (ERRD)
    ) dut (
        .io_clk  (io_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sdat [NS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One command end to end. k = WAIT_ACK cycle index of the ack pulse (-1 = none).
    task automatic run_txn(input string nm, input logic wr, input logic [15:0] hi,
                           input logic [15:0] lo, input logic [31:0] wd, input int k,
                           input logic [NS-1:0] mask, input int hold);
        int          exp_cyc, rsp_cyc, c;
        logic [31:0] exp_d, got_d;
        logic        exp_e, got_e;
        logic [NS-1:0] oh;
        bit          vidx, sync_ok, bus_ok, resp_ok, stable_ok;

        // Reference: what the response should be and in which cycle it appears.
        vidx = int'(hi) < NS;
        oh   = '0;
        if (vidx) oh[hi[2:0]] = 1'b1;
        exp_d = 32'h0;
        if (!vidx) begin
            exp_cyc = 1; exp_e = 1'b1;
        end else if (wr) begin
            exp_cyc = 2; exp_e = 1'b0;
        end else if (k >= 0 && k <= TMO && mask != '0) begin
            exp_cyc = 3 + k;
            exp_e   = $countones(mask) > 1;
            for (int i = 0; i < NS; i++) begin
                if (mask[i]) begin
                    exp_d = sdat[i];
                    break;
                end
            end
        end else begin
            exp_cyc = TMO + 3; exp_d = ERRD; exp_e = 1'b1;
        end

        for (int i = 0; i < NS; i++) bus.io_rd_data[32*i +: 32] = sdat[i];

        @(negedge io_clk);
        check({nm, ":cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = {hi, lo};
        bus.cmd_wdata = wd;
        bus.rsp_ready = (hold == 0);
        @(posedge io_clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;

        rsp_cyc = -1; sync_ok = 1; bus_ok = 1; resp_ok = 1; stable_ok = 1;
        got_d = '0; got_e = 1'b0; c = 0;
        while (rsp_cyc < 0 && c < TMO + 8) begin
            c++;
            if (c == 1)                  bus.io_rd_ack = NS'($urandom_range(1, 255));
            else if (k >= 0 && c == 2 + k) bus.io_rd_ack = mask;
            else                         bus.io_rd_ack = '0;
            @(negedge io_clk);
            if (bus.rsp_valid) begin
                rsp_cyc = c; got_d = bus.rsp_data; got_e = bus.rsp_err;
            end else begin
                if (bus.io_sync !== (vidx && c == 1)) sync_ok = 0;
                if (bus.cmd_ready !== 1'b0) bus_ok = 0;
                if (vidx) begin
                    if (bus.io_sel !== oh || bus.io_addr !== lo ||
                        bus.io_rd_en !== ~wr || bus.io_wr_en !== wr) bus_ok = 0;
                    if (bus.io_wr_data !== wd) bus_ok = 0;
                end else if (bus.io_sel !== '0 || bus.io_rd_en || bus.io_wr_en) begin
                    bus_ok = 0;
                end
                @(posedge io_clk);
                #1;
            end
        end

        if (rsp_cyc < 0) begin
            check({nm, ":rsp_seen"}, 32'd0, 32'd1);
        end else begin
            if (bus.io_sel !== '0 || bus.io_rd_en || bus.io_wr_en || bus.io_sync ||
                bus.cmd_ready !== 1'b0) resp_ok = 0;
            if (vidx && (bus.io_addr !== lo || bus.io_wr_data !== wd)) resp_ok = 0;
            for (int h = 0; h < hold; h++) begin
                @(posedge io_clk);
                #1;
                bus.io_rd_ack = NS'($urandom);
                @(negedge io_clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== got_d ||
                    bus.rsp_err !== got_e || bus.cmd_ready !== 1'b0) stable_ok = 0;
            end
            bus.rsp_ready = 1'b1;
            bus.io_rd_ack = '0;
            @(negedge io_clk);
            check({nm, ":cyc"},      32'(rsp_cyc), 32'(exp_cyc));
            check({nm, ":data"},     got_d, exp_d);
            check({nm, ":err"},      {31'd0, got_e}, {31'd0, exp_e});
            check({nm, ":sync"},     {31'd0, sync_ok}, 32'd1);
            check({nm, ":bus"},      {31'd0, bus_ok}, 32'd1);
            check({nm, ":resp_bus"}, {31'd0, resp_ok}, 32'd1);
            if (hold > 0) check({nm, ":stable"}, {31'd0, stable_ok}, 32'd1);
            check({nm, ":post"}, {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
        end
        bus.io_rd_ack = '0;
    endtask

    initial begin
        logic [15:0]   r_hi;
        logic [NS-1:0] r_mask;
        int            r_k;

        bus.cmd_valid  = 1'b0;
        bus.cmd_wr     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.rsp_ready  = 1'b1;
        bus.io_rd_data = '0;
        bus.io_rd_ack  = '0;
        for (int i = 0; i < NS; i++) sdat[i] = $urandom;

        // Outputs under reset.
        #2;
        check("rst0:cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst0:rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst0:io_sel",    {24'd0, bus.io_sel}, 32'd0);
        check("rst0:io_sync",   {31'd0, bus.io_sync}, 32'd0);
        repeat (3) @(negedge io_clk);
        reset_n = 1'b1;
        @(negedge io_clk);

        // Directed cases.
        run_txn("t1_wr", 1'b1, 16'h0002, 16'h8000, 32'h0001_FFFF, -1, '0, 0);
        sdat[2] = 32'hFFFF_FFFF;
        run_txn("t2_rd", 1'b0, 16'h0002, 16'h8000, 32'h0, 0, 8'b0000_0100, 0);
        run_txn("t3_tmo", 1'b0, 16'h0005, 16'h1234, 32'h0, -1, '0, 0);
        run_txn("t4_bad", 1'b0, 16'h0009, 16'h0000, 32'h0, 0, 8'b0000_0001, 0);
        sdat[1] = 32'h11;
        sdat[3] = 32'h33;
        run_txn("t5_multi", 1'b0, 16'h0003, 16'h0040, 32'h0, 0, 8'b0000_1010, 5);
        run_txn("t5b_last", 1'b0, 16'h0007, 16'h0abc, 32'h0, TMO, 8'b1000_0000, 0);

        // Reset during WAIT_ACK.
        @(negedge io_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = 32'h0004_0010;
        bus.cmd_wdata = 32'hA5A5_5A5A;
        @(posedge io_clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(posedge io_clk);
        #3;
        check("t6:pre_rd_en", {31'd0, bus.io_rd_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6:outs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.io_sync,
                          bus.io_rd_en, bus.io_wr_en, 26'd0}, 32'd0);
        check("t6:sel",     {24'd0, bus.io_sel}, 32'd0);
        check("t6:addr",    {16'd0, bus.io_addr}, 32'd0);
        check("t6:wr_data", bus.io_wr_data, 32'd0);
        check("t6:rsp_data", bus.rsp_data, 32'd0);
        repeat (2) @(negedge io_clk);
        reset_n = 1'b1;
        @(negedge io_clk);
        check("t6:ready_after", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
        repeat (TMO + 5) @(negedge io_clk);
        check("t6:no_stale", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NS; i++) sdat[i] = $urandom;
            r_hi = 16'($urandom_range(0, 10));
            if (r_hi == 16'd10) r_hi = 16'($urandom) | 16'h0100;
            if ($urandom_range(0, 3) != 0) r_mask = NS'(1) << $urandom_range(0, NS - 1);
            else                           r_mask = NS'($urandom_range(1, 255));
            r_k = $urandom_range(0, 4) == 0 ? -1 : int'($urandom_range(0, TMO + 3));
            run_txn($sformatf("rnd%0d", n), 1'($urandom), r_hi, 16'($urandom), $urandom,
                    r_k, r_mask, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
